// File: rtl/latch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : latch_ctrl_pkg
// Purpose  : Shared types and helpers for the latch bank arbiter.
//            - state_t     : write-sequencer state encoding
//            - cnt_width() : width of the shared GATE/HOLD cycle counter
// Revision : 1.0  initial release
// ============================================================================
package latch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_GATE  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_ACK   = 3'd4
  } state_t;

  // One counter serves both the GATE and HOLD phases, so it must hold the
  // larger of the two preload values.
  function automatic int cnt_width(input int gate_cycles, input int hold_cycles);
    int max_v;
    max_v = (gate_cycles > hold_cycles) ? gate_cycles : hold_cycles;
    return $clog2(max_v + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin winner select. Searches req upward
//            from ptr, wrapping modulo N; the pointer register lives in the
//            parent.
// Ports    : req    [N-1:0] in  - request vector
//            ptr    [W-1:0] in  - highest-priority index
//            winner [W-1:0] out - selected index (0 when !valid)
//            valid          out - at least one request present
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         valid
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;

  // Rotate so that bit 0 of w_rot corresponds to requester ptr; the first
  // set bit of w_rot is then the round-robin winner offset.
  assign w_dbl = {req, req};
  assign w_rot = w_dbl[N-1:0] == '0 ? '0 : N'(w_dbl >> ptr);

  always_comb begin
    int sum;
    valid  = 1'b0;
    winner = '0;
    sum    = 0;
    for (int i = 0; i < N; i++) begin
      if (!valid && w_rot[i]) begin
        valid = 1'b1;
        sum   = int'(ptr) + i;
        if (sum >= N) begin
          sum = sum - N;
        end
        winner = W'(sum);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/latch_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : latch_bank_arbiter
// Purpose  : Round-robin arbiter and write sequencer sharing one bank of
//            D latches (gate = latch_en, d = latch_d) between NUM_REQ
//            requesters. Each grant runs SETUP -> GATE -> HOLD -> ACK and
//            reports a readback mismatch on wr_err together with ack.
// Ports    : clk, rst_n            - clock (rising), async active-low reset
//            req      [NUM_REQ]    - level requests, held until ack
//            wdata    [NUM_REQ*DATA_W] - requester i at [i*DATA_W +: DATA_W]
//            latch_q  [DATA_W]     - latch bank readback
//            gnt      [NUM_REQ]    - registered one-hot grant
//            ack      [NUM_REQ]    - one-cycle completion pulse
//            wr_err                - readback mismatch, coincident with ack
//            latch_d  [DATA_W]     - registered latch data
//            latch_en              - registered latch gate
//            busy                  - high whenever not IDLE
// Revision : 1.0  initial release
// ============================================================================
module latch_bank_arbiter
  import latch_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int GATE_CYCLES = 2,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0]         latch_q,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      wr_err,
  output logic [DATA_W-1:0]         latch_d,
  output logic                      latch_en,
  output logic                      busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = cnt_width(GATE_CYCLES, HOLD_CYCLES);
  localparam logic [CNT_W-1:0] C_GATE_LOAD = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [PTR_W-1:0] C_PTR_LAST  = PTR_W'(NUM_REQ - 1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [NUM_REQ-1:0] w_gnt_nxt, w_ack_nxt;
  logic [DATA_W-1:0]  w_d_nxt, w_sel_data;
  logic               w_en_nxt, w_err_nxt;
  logic [PTR_W-1:0]   w_winner;
  logic               w_valid;

  rr_arbiter #(
    .N (NUM_REQ),
    .W (PTR_W)
  ) u_rr_arbiter (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_winner),
    .valid  (w_valid)
  );

  // Winner's write data, selected with constant slices only.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == PTR_W'(i)) begin
        w_sel_data = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and next-output logic. latch_en is computed one cycle ahead
  // and registered so the latch gate is driven straight from a flop.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = gnt;
    w_d_nxt     = latch_d;
    w_en_nxt    = 1'b0;
    w_ack_nxt   = '0;
    w_err_nxt   = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_valid) begin
          w_gnt_nxt   = NUM_REQ'(1) << w_winner;
          w_d_nxt     = w_sel_data;
          w_ptr_nxt   = (w_winner == C_PTR_LAST) ? '0 : w_winner + PTR_W'(1);
          w_state_nxt = ST_SETUP;
        end
      end

      ST_SETUP: begin
        w_state_nxt = ST_GATE;
        w_cnt_nxt   = C_GATE_LOAD;
        w_en_nxt    = 1'b1;
      end

      ST_GATE: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = C_HOLD_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          w_en_nxt  = 1'b1;
        end
      end

      ST_HOLD: begin
        if (r_cnt == '0) begin
          // Final HOLD cycle: the registered compare becomes wr_err in ACK.
          w_state_nxt = ST_ACK;
          w_ack_nxt   = gnt;
          w_err_nxt   = (latch_q != latch_d);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      ST_ACK: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_ptr    <= '0;
      gnt      <= '0;
      ack      <= '0;
      wr_err   <= 1'b0;
      latch_d  <= '0;
      latch_en <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ptr    <= w_ptr_nxt;
      gnt      <= w_gnt_nxt;
      ack      <= w_ack_nxt;
      wr_err   <= w_err_nxt;
      latch_d  <= w_d_nxt;
      latch_en <= w_en_nxt;
    end
  end

  assign busy = (r_state != ST_IDLE);

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack));
  a_ack_gnt:    assert property (@(posedge clk) disable iff (!rst_n) ((ack & gnt) == ack));
  a_en_gate:    assert property (@(posedge clk) disable iff (!rst_n) (!latch_en || r_state == ST_GATE));

endmodule
`default_nettype wire

// File: tb/tb_latch_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_latch_bank_arbiter
// Purpose  : Directed self-checking bench. Instance a uses default
//            parameters, instance b uses GATE_CYCLES=1 / HOLD_CYCLES=3.
//            Each instance drives a behavioural latch bank model.
// Revision : 1.0  initial release
// ============================================================================
module tb_latch_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fault;

  logic [3:0]  req_a, gnt_a, ack_a;
  logic [31:0] wdata_a;
  logic [7:0]  q_a, d_a, mem_a;
  logic        err_a, en_a, busy_a;

  logic [3:0]  req_b, gnt_b, ack_b;
  logic [31:0] wdata_b;
  logic [7:0]  q_b, d_b, mem_b;
  logic        err_b, en_b, busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  latch_bank_arbiter u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .wdata(wdata_a), .latch_q(q_a),
    .gnt(gnt_a), .ack(ack_a), .wr_err(err_a), .latch_d(d_a),
    .latch_en(en_a), .busy(busy_a)
  );

  latch_bank_arbiter #(
    .NUM_REQ(4), .DATA_W(8), .GATE_CYCLES(1), .HOLD_CYCLES(3)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .wdata(wdata_b), .latch_q(q_b),
    .gnt(gnt_b), .ack(ack_b), .wr_err(err_b), .latch_d(d_b),
    .latch_en(en_b), .busy(busy_b)
  );

  // Transparent-high D latch banks.
  always_latch begin
    if (en_a) mem_a <= d_a;
  end
  always_latch begin
    if (en_b) mem_b <= d_b;
  end
  assign q_a = fault ? 8'h00 : mem_a;
  assign q_b = mem_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Called at a negedge in IDLE with req_a already set (cycle c0).
  task automatic do_txn(input int w, input logic [7:0] d, input logic err);
    logic [3:0] oh;
    oh = 4'(1 << w);
    tick();  // c1
    check("c1_gnt", 32'(gnt_a), 32'(oh));
    check("c1_latch_d", 32'(d_a), 32'(d));
    check("c1_latch_en", 32'(en_a), 32'd0);
    check("c1_busy", 32'(busy_a), 32'd1);
    tick();  // c2
    check("c2_latch_en", 32'(en_a), 32'd1);
    tick();  // c3
    check("c3_latch_en", 32'(en_a), 32'd1);
    check("c3_latch_d", 32'(d_a), 32'(d));
    tick();  // c4
    check("c4_latch_en", 32'(en_a), 32'd0);
    check("c4_latch_d", 32'(d_a), 32'(d));
    check("c4_ack", 32'(ack_a), 32'd0);
    tick();  // c5
    check("c5_ack", 32'(ack_a), 32'(oh));
    check("c5_wr_err", 32'(err_a), 32'(err));
    check("c5_gnt", 32'(gnt_a), 32'(oh));
    req_a[w] = 1'b0;
    tick();  // c6
    check("c6_ack", 32'(ack_a), 32'd0);
    check("c6_wr_err", 32'(err_a), 32'd0);
    check("c6_busy", 32'(busy_a), 32'd0);
    check("c6_gnt", 32'(gnt_a), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    fault   = 1'b0;
    req_a   = '0;
    wdata_a = '0;
    req_b   = '0;
    wdata_b = '0;
    #1;
    check("rst_gnt", 32'(gnt_a), 32'd0);
    check("rst_ack", 32'(ack_a), 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    check("rst_latch_d", 32'(d_a), 32'd0);
    check("rst_latch_en", 32'(en_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single request from requester 1.
    wdata_a[15:8] = 8'hA5;
    req_a = 4'b0010;
    do_txn(1, 8'hA5, 1'b0);

    // Return the pointer to 0, then full contention.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wdata_a = {8'h44, 8'h33, 8'h22, 8'h11};
    req_a = 4'b1111;
    do_txn(0, 8'h11, 1'b0);
    do_txn(1, 8'h22, 1'b0);
    do_txn(2, 8'h33, 1'b0);
    do_txn(3, 8'h44, 1'b0);

    // Pointer wrapped to 0: 0 before 3.
    req_a = 4'b1001;
    do_txn(0, 8'h11, 1'b0);
    do_txn(3, 8'h44, 1'b0);
    // Move pointer to 1, then 3 before 0.
    req_a = 4'b0001;
    do_txn(0, 8'h11, 1'b0);
    req_a = 4'b1001;
    do_txn(3, 8'h44, 1'b0);
    do_txn(0, 8'h11, 1'b0);

    // Readback fault.
    fault = 1'b1;
    wdata_a[7:0] = 8'h3C;
    req_a = 4'b0001;
    do_txn(0, 8'h3C, 1'b1);
    fault = 1'b0;

    // Reset mid-GATE.
    req_a = 4'b0100;
    tick();
    tick();
    check("pre_rst_latch_en", 32'(en_a), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_latch_en", 32'(en_a), 32'd0);
    check("async_rst_gnt", 32'(gnt_a), 32'd0);
    check("async_rst_busy", 32'(busy_a), 32'd0);
    req_a = 4'b0000;
    tick();
    rst_n = 1'b1;
    wdata_a[7:0] = 8'h77;
    req_a = 4'b0001;
    do_txn(0, 8'h77, 1'b0);

    // GATE_CYCLES=1, HOLD_CYCLES=3 instance.
    wdata_b[7:0] = 8'h5A;
    req_b = 4'b0001;
    tick();  // c1
    check("b_c1_gnt", 32'(gnt_b), 32'd1);
    check("b_c1_latch_en", 32'(en_b), 32'd0);
    tick();  // c2
    check("b_c2_latch_en", 32'(en_b), 32'd1);
    wdata_b[7:0] = 8'hFF;
    tick();  // c3
    check("b_c3_latch_en", 32'(en_b), 32'd0);
    check("b_c3_latch_d", 32'(d_b), 32'h5A);
    tick();  // c4
    check("b_c4_latch_en", 32'(en_b), 32'd0);
    tick();  // c5
    check("b_c5_ack", 32'(ack_b), 32'd0);
    check("b_c5_latch_d", 32'(d_b), 32'h5A);
    tick();  // c6
    check("b_c6_ack", 32'(ack_b), 32'd1);
    check("b_c6_wr_err", 32'(err_b), 32'd0);
    req_b = 4'b0000;
    tick();  // c7
    check("b_c7_busy", 32'(busy_b), 32'd0);
    check("b_c7_ack", 32'(ack_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
